// File: rtl/vscpu_param.sv
// Parametrised VerySimpleCPU: 16-opcode memory-to-memory core with a req/ack memory port,
// branch-to-self halt detection and a retired-instruction counter.
module vscpu_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       retired
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_RD_A, S_RD_B, S_RD_IND, S_WRITE, S_HALT
   } state_t;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_ADDI  = 4'd1;
   localparam logic [3:0] OP_NAND  = 4'd2;
   localparam logic [3:0] OP_NANDI = 4'd3;
   localparam logic [3:0] OP_SRL   = 4'd4;
   localparam logic [3:0] OP_SRLI  = 4'd5;
   localparam logic [3:0] OP_LT    = 4'd6;
   localparam logic [3:0] OP_LTI   = 4'd7;
   localparam logic [3:0] OP_CP    = 4'd8;
   localparam logic [3:0] OP_CPIM  = 4'd9;
   localparam logic [3:0] OP_CPI   = 4'd10;
   localparam logic [3:0] OP_CPII  = 4'd11;
   localparam logic [3:0] OP_BZJ   = 4'd12;
   localparam logic [3:0] OP_BZJI  = 4'd13;
   localparam logic [3:0] OP_MUL   = 4'd14;
   localparam logic [3:0] OP_MULI  = 4'd15;

   localparam int IW_W = 4 + 2*ADDR_W;
   localparam logic [DATA_W-1:0] DW_VAL = DATA_W'(DATA_W);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [IW_W-1:0]     iw_q, iw_d;
   logic [DATA_W-1:0]   r1_q, r1_d;
   logic [31:0]         retired_q, retired_d;
   logic                halted_q, halted_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic [3:0]          op;
   logic [ADDR_W-1:0]   a_fld, b_fld;
   logic [3:0]          f_op;
   logic [ADDR_W-1:0]   f_a, f_b;
   logic                done;
   logic                br_en;
   logic [ADDR_W-1:0]   br_tgt;

   assign op    = iw_q[IW_W-1 -: 4];
   assign a_fld = iw_q[2*ADDR_W-1:ADDR_W];
   assign b_fld = iw_q[ADDR_W-1:0];
   assign f_op  = mem_rdata[DATA_W-1 -: 4];
   assign f_a   = mem_rdata[2*ADDR_W-1:ADDR_W];
   assign f_b   = mem_rdata[ADDR_W-1:0];
   assign done  = mem_req_q & mem_ack;

   // Ops are paired (reg, imm) so op[3:1] selects the arithmetic.
   function automatic logic [DATA_W-1:0] alu(input logic [2:0] grp,
                                             input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
      logic [DATA_W-1:0] r;
      r = '0;
      case (grp)
         3'd0:    r = x + y;
         3'd1:    r = ~(x & y);
         3'd2:    r = (y < DW_VAL) ? (x >> y) : (x << (y - DW_VAL));
         3'd3:    r = {{(DATA_W-1){1'b0}}, (x < y)};
         3'd7:    r = x * y;
         default: r = y;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      iw_d        = iw_q;
      r1_d        = r1_q;
      retired_d   = retired_q;
      halted_d    = halted_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      br_en       = 1'b0;
      br_tgt      = '0;

      // Each transition sets up the next request so accesses run back to back.
      case (state_q)
         S_IDLE: begin
            state_d    = S_FETCH;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_q;
         end
         S_FETCH: if (done) begin
            iw_d     = {f_op, f_a, f_b};
            mem_we_d = 1'b0;
            case (f_op)
               OP_CP, OP_CPI: begin
                  state_d    = S_RD_B;
                  mem_addr_d = f_b;
               end
               OP_CPIM: begin
                  state_d     = S_WRITE;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = f_a;
                  mem_wdata_d = DATA_W'(f_b);
               end
               default: begin
                  state_d    = S_RD_A;
                  mem_addr_d = f_a;
               end
            endcase
         end
         S_RD_A: if (done) begin
            r1_d = mem_rdata;
            case (op)
               OP_BZJI: begin
                  br_en  = 1'b1;
                  br_tgt = mem_rdata[ADDR_W-1:0] + b_fld;
               end
               OP_ADDI, OP_NANDI, OP_SRLI, OP_LTI, OP_MULI: begin
                  state_d     = S_WRITE;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = a_fld;
                  mem_wdata_d = alu(op[3:1], mem_rdata, DATA_W'(b_fld));
               end
               default: begin
                  state_d    = S_RD_B;
                  mem_addr_d = b_fld;
               end
            endcase
         end
         S_RD_B: if (done) begin
            case (op)
               OP_CP: begin
                  state_d     = S_WRITE;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = a_fld;
                  mem_wdata_d = mem_rdata;
               end
               OP_CPI: begin
                  state_d    = S_RD_IND;
                  mem_addr_d = mem_rdata[ADDR_W-1:0];
               end
               OP_CPII: begin
                  state_d     = S_WRITE;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = r1_q[ADDR_W-1:0];
                  mem_wdata_d = mem_rdata;
               end
               OP_BZJ: begin
                  br_en  = 1'b1;
                  br_tgt = (mem_rdata == '0) ? r1_q[ADDR_W-1:0] : pc_q + 1'b1;
               end
               default: begin
                  state_d     = S_WRITE;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = a_fld;
                  mem_wdata_d = alu(op[3:1], r1_q, mem_rdata);
               end
            endcase
         end
         S_RD_IND: if (done) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = a_fld;
            mem_wdata_d = mem_rdata;
         end
         S_WRITE: if (done) begin
            state_d    = S_FETCH;
            pc_d       = pc_q + 1'b1;
            retired_d  = retired_q + 32'd1;
            mem_we_d   = 1'b0;
            mem_addr_d = pc_q + 1'b1;
         end
         S_HALT: begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      // A branch landing on its own address parks the core for good.
      if (br_en) begin
         retired_d = retired_q + 32'd1;
         mem_we_d  = 1'b0;
         if (br_tgt == pc_q) begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            mem_req_d = 1'b0;
         end else begin
            state_d    = S_FETCH;
            pc_d       = br_tgt;
            mem_addr_d = br_tgt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         iw_q        <= '0;
         r1_q        <= '0;
         retired_q   <= '0;
         halted_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         iw_q        <= iw_d;
         r1_q        <= r1_d;
         retired_q   <= retired_d;
         halted_q    <= halted_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign halted    = halted_q;
   assign pc        = pc_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_vscpu_param.sv
// Directed bench for vscpu_param: behavioural RAM with configurable wait states,
// hand-computed expected memory/pc/counter values checked with immediate assertions.
module tb_vscpu_param;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 14;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              halted;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       retired;

   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   int                waitCfg = 0;
   int                waitCnt;
   int                xferCount;
   int                reqCycles;
   logic              pending;
   logic              unstable;
   logic [ADDR_W-1:0] prevAddr;
   logic              prevWe;
   logic [DATA_W-1:0] prevWdata;
   int                vectors = 0;
   int                miscompares = 0;
   int                snapXfers;

   vscpu_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .halted    (halted),
      .pc        (pc),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   assign mem_ack   = mem_req && (waitCnt == waitCfg);
   assign mem_rdata = mem[mem_addr];

   // RAM responder: counts transfers/busy cycles and flags any request that changes while waiting.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         waitCnt   <= 0;
         xferCount <= 0;
         reqCycles <= 0;
         pending   <= 1'b0;
         unstable  <= 1'b0;
      end else begin
         if (mem_req) reqCycles <= reqCycles + 1;
         if (pending && (!mem_req || mem_addr != prevAddr || mem_we != prevWe ||
                         (mem_we && mem_wdata != prevWdata)))
            unstable <= 1'b1;
         if (mem_req && mem_ack) begin
            xferCount <= xferCount + 1;
            waitCnt   <= 0;
            pending   <= 1'b0;
            if (mem_we) mem[mem_addr] <= mem_wdata;
         end else if (mem_req) begin
            waitCnt   <= waitCnt + 1;
            pending   <= 1'b1;
            prevAddr  <= mem_addr;
            prevWe    <= mem_we;
            prevWdata <= mem_wdata;
         end else begin
            pending <= 1'b0;
         end
      end
   end

   function automatic logic [31:0] mkIw(input logic [3:0] op, input logic [13:0] a,
                                        input logic [13:0] b);
      return {op, a, b};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearMem();
      for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'd0;
   endtask

   task automatic holdReset();
      @(negedge clk);
      rst = 1'b0;
      clearMem();
   endtask

   task automatic applyStimulus(input int waits);
      waitCfg = waits;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic waitRetired(input int n, input int budget);
      for (int i = 0; i < budget && retired != 32'(n); i++) @(negedge clk);
   endtask

   task automatic waitHalted(input int budget);
      for (int i = 0; i < budget && !halted; i++) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #2 rst = 1'b0;
      clearMem();
      @(negedge clk);
      checkOutput("rst_req",     mem_req,   0);
      checkOutput("rst_we",      mem_we,    0);
      checkOutput("rst_addr",    mem_addr,  0);
      checkOutput("rst_wdata",   mem_wdata, 0);
      checkOutput("rst_pc",      pc,        0);
      checkOutput("rst_retired", retired,   0);
      checkOutput("rst_halted",  halted,    0);

      $display("[TB] ADD, zero wait states");
      mem[0]  = mkIw(4'd0, 14'd20, 14'd21);
      mem[20] = 32'd7;
      mem[21] = 32'd5;
      applyStimulus(0);
      waitRetired(1, 100);
      checkOutput("add0_retired", retired,   1);
      checkOutput("add0_result",  mem[20],   12);
      checkOutput("add0_pc",      pc,        1);
      checkOutput("add0_xfers",   xferCount, 4);
      checkOutput("add0_cycles",  reqCycles, 4);

      $display("[TB] ADD, three wait states per access");
      holdReset();
      mem[0]  = mkIw(4'd0, 14'd20, 14'd21);
      mem[20] = 32'd7;
      mem[21] = 32'd5;
      applyStimulus(3);
      waitRetired(1, 200);
      checkOutput("add3_retired", retired,   1);
      checkOutput("add3_result",  mem[20],   12);
      checkOutput("add3_pc",      pc,        1);
      checkOutput("add3_xfers",   xferCount, 4);
      checkOutput("add3_cycles",  reqCycles, 16);
      checkOutput("add3_stable",  unstable,  0);

      $display("[TB] CPIi then CPI");
      holdReset();
      mem[0]  = mkIw(4'd11, 14'd30, 14'd31);
      mem[1]  = mkIw(4'd10, 14'd50, 14'd30);
      mem[30] = 32'd40;
      mem[31] = 32'd99;
      applyStimulus(1);
      waitRetired(2, 300);
      checkOutput("cpii_result", mem[40], 99);
      checkOutput("cpi_result",  mem[50], 99);
      checkOutput("cpi_pc",      pc,      2);
      checkOutput("cpi_stable",  unstable, 0);

      $display("[TB] ALU mix, shift boundaries, branches, halt");
      holdReset();
      mem[0]  = mkIw(4'd4,  14'd20, 14'd21);
      mem[1]  = mkIw(4'd4,  14'd22, 14'd23);
      mem[2]  = mkIw(4'd4,  14'd24, 14'd25);
      mem[3]  = mkIw(4'd5,  14'd26, 14'd3);
      mem[4]  = mkIw(4'd1,  14'd27, 14'd100);
      mem[5]  = mkIw(4'd2,  14'd28, 14'd29);
      mem[6]  = mkIw(4'd6,  14'd30, 14'd31);
      mem[7]  = mkIw(4'd14, 14'd32, 14'd33);
      mem[8]  = mkIw(4'd9,  14'd34, 14'd77);
      mem[9]  = mkIw(4'd8,  14'd35, 14'd36);
      mem[10] = mkIw(4'd12, 14'd37, 14'd38);
      mem[11] = mkIw(4'd9,  14'd39, 14'd1);
      mem[12] = mkIw(4'd13, 14'd40, 14'd12);
      mem[13] = mkIw(4'd9,  14'd41, 14'd5);
      mem[14] = mkIw(4'd13, 14'd42, 14'd14);
      mem[20] = 32'd1;  mem[21] = 32'd33;
      mem[22] = 32'd1;  mem[23] = 32'd31;
      mem[24] = 32'd1;  mem[25] = 32'd64;
      mem[26] = 32'd16;
      mem[27] = 32'd5;
      mem[28] = 32'hF0F0_F0F0; mem[29] = 32'hFF00_FF00;
      mem[30] = 32'd3;  mem[31] = 32'd9;
      mem[32] = 32'h0001_0000; mem[33] = 32'h0001_0003;
      mem[36] = 32'hDEAD_BEEF;
      mem[37] = 32'd12; mem[38] = 32'd0;
      mem[40] = 32'd2;
      mem[42] = 32'd0;
      applyStimulus(0);
      waitHalted(1000);
      checkOutput("mix_halted",  halted,  1);
      checkOutput("mix_srl33",   mem[20], 2);
      checkOutput("mix_srl31",   mem[22], 0);
      checkOutput("mix_srl64",   mem[24], 0);
      checkOutput("mix_srli",    mem[26], 2);
      checkOutput("mix_addi",    mem[27], 105);
      checkOutput("mix_nand",    mem[28], 32'h0FFF_0FFF);
      checkOutput("mix_lt",      mem[30], 1);
      checkOutput("mix_mul",     mem[32], 32'h0003_0000);
      checkOutput("mix_cpi",     mem[34], 77);
      checkOutput("mix_cp",      mem[35], 32'hDEAD_BEEF);
      checkOutput("mix_bzj",     mem[39], 0);
      checkOutput("mix_bzji",    mem[41], 0);
      checkOutput("mix_pc",      pc,      14);
      checkOutput("mix_retired", retired, 13);
      checkOutput("mix_req",     mem_req, 0);

      $display("[TB] Halt on branch-to-self");
      holdReset();
      mem[5]  = mkIw(4'd13, 14'd60, 14'd5);
      mem[60] = 32'd0;
      applyStimulus(2);
      waitHalted(500);
      checkOutput("halt_halted",  halted,  1);
      checkOutput("halt_req",     mem_req, 0);
      checkOutput("halt_pc",      pc,      5);
      checkOutput("halt_retired", retired, 6);
      snapXfers = xferCount;
      repeat (6) @(negedge clk);
      checkOutput("halt_pc_frozen",  pc,        5);
      checkOutput("halt_ret_frozen", retired,   6);
      checkOutput("halt_no_access",  xferCount, snapXfers);

      $display("[TB] Reset during a withheld write");
      holdReset();
      mem[0]  = mkIw(4'd9, 14'd70, 14'd123);
      mem[70] = 32'h55;
      applyStimulus(20);
      for (int i = 0; i < 100 && !(mem_req && mem_we); i++) @(negedge clk);
      checkOutput("rmw_in_write", mem_req && mem_we, 1);
      checkOutput("rmw_wdata",    mem_wdata, 123);
      rst = 1'b0;
      #1;
      checkOutput("rmw_req",   mem_req,   0);
      checkOutput("rmw_we",    mem_we,    0);
      checkOutput("rmw_addr",  mem_addr,  0);
      checkOutput("rmw_wdata0", mem_wdata, 0);
      checkOutput("rmw_pc",    pc,        0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rmw_target", mem[70], 32'h55);
      waitCfg = 0;
      rst = 1'b1;
      for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
      checkOutput("rmw_refetch_req",  mem_req,  1);
      checkOutput("rmw_refetch_addr", mem_addr, 0);
      checkOutput("rmw_refetch_we",   mem_we,   0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
